// File: rtl/pll_lock_supervisor_pkg.sv
// Shared LVDS clock-tree constants: supervisor state encoding, loss counter width
// and the reference/serial clock frequencies used by the serializer.
package lvds_clk_pkg;

    localparam int LOSS_W     = 8;
    localparam int REF_CLK_HZ = 48_000_000;
    localparam int SER_CLK_HZ = 336_000_000;

    typedef enum logic [2:0] {
        ST_OFF       = 3'd0,
        ST_RST_PLL   = 3'd1,
        ST_WAIT_LOCK = 3'd2,
        ST_STABLE    = 3'd3,
        ST_RELEASE   = 3'd4,
        ST_RUN       = 3'd5,
        ST_FAULT     = 3'd6
    } sup_state_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pll_lock_supervisor_if.sv
// Control/status bundle between the PLL lock supervisor (slave) and whoever
// enables it and consumes the downstream resets (master).
interface pll_lock_supervisor_if #(
    parameter int NUM_RST = 3,
    parameter int RETRY_W = 3
);
    import lvds_clk_pkg::*;

    logic                 EN;
    logic                 PLL_LOCK;
    logic                 PLL_RST;
    logic [NUM_RST-1:0]   RST_N_OUT;
    logic                 READY;
    logic                 FAULT;
    logic [RETRY_W-1:0]   RETRY_CNT;
    logic [LOSS_W-1:0]    LOSS_CNT;
    logic [2:0]           STATE;

    modport slave (
        input  EN, PLL_LOCK,
        output PLL_RST, RST_N_OUT, READY, FAULT, RETRY_CNT, LOSS_CNT, STATE
    );

    modport master (
        output EN, PLL_LOCK,
        input  PLL_RST, RST_N_OUT, READY, FAULT, RETRY_CNT, LOSS_CNT, STATE
    );

endinterface

// File: rtl/pll_lock_supervisor_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous status bit; resets to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL supervisor: pulses PLL_RST, debounces the synced lock, retries on timeout
// and releases the downstream reset domains one by one.
module pll_lock_supervisor
    import lvds_clk_pkg::*;
#(
    parameter int RST_PULSE_CYC    = 16,
    parameter int LOCK_STABLE_CYC  = 4800,
    parameter int LOCK_TIMEOUT_CYC = 480000,
    parameter int NUM_RST          = 3,
    parameter int STAGE_GAP_CYC    = 64,
    parameter int MAX_RETRY        = 7,
    parameter int RETRY_W          = $clog2(MAX_RETRY + 1)
) (
    input logic                  CLKI,
    input logic                  RSTN,
    pll_lock_supervisor_if.slave bus
);

    localparam int CNT_MAX = max2(RST_PULSE_CYC, (NUM_RST - 1) * STAGE_GAP_CYC);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int TMO_W   = $clog2(LOCK_TIMEOUT_CYC + 1);
    localparam int STB_W   = $clog2(LOCK_STABLE_CYC + 1);

    localparam logic [CNT_W-1:0]   CNT_SAT    = CNT_W'(CNT_MAX);
    localparam logic [CNT_W-1:0]   PULSE_LAST = CNT_W'(RST_PULSE_CYC - 1);
    localparam logic [CNT_W-1:0]   REL_LAST   = CNT_W'((NUM_RST - 1) * STAGE_GAP_CYC);
    localparam logic [TMO_W-1:0]   TMO_LAST   = TMO_W'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [STB_W-1:0]   STB_LAST   = STB_W'(LOCK_STABLE_CYC - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX  = RETRY_W'(MAX_RETRY);

    sup_state_t          r_state;
    sup_state_t          w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [TMO_W-1:0]    r_tmo;
    logic [STB_W-1:0]    r_stb;
    logic                r_pll_rst;
    logic [NUM_RST-1:0]  r_rst_n;
    logic [NUM_RST-1:0]  w_rst_n_nxt;
    logic                r_ready;
    logic                r_fault;
    logic [RETRY_W-1:0]  r_retry;
    logic [RETRY_W-1:0]  w_retry_nxt;
    logic [LOSS_W-1:0]   r_loss;
    logic [LOSS_W-1:0]   w_loss_nxt;
    logic                w_lock_s;
    logic                w_tmo_hit;

    sync_2ff u_lock_sync (
        .clk   (CLKI),
        .rst_n (RSTN),
        .i_d   (bus.PLL_LOCK),
        .o_q   (w_lock_s)
    );

    assign w_tmo_hit = (r_tmo == TMO_LAST);

    // Timeout outranks both lock events; EN low overrides everything except LOSS_CNT.
    always_comb begin
        w_state_nxt = r_state;
        w_rst_n_nxt = r_rst_n;
        w_retry_nxt = r_retry;
        w_loss_nxt  = r_loss;
        case (r_state)
            ST_OFF:     w_state_nxt = ST_RST_PLL;
            ST_RST_PLL: begin
                if (r_cnt == PULSE_LAST) w_state_nxt = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK, ST_STABLE: begin
                if (w_tmo_hit) begin
                    if (r_retry == RETRY_MAX) begin
                        w_state_nxt = ST_FAULT;
                    end else begin
                        w_retry_nxt = r_retry + 1'b1;
                        w_state_nxt = ST_RST_PLL;
                    end
                end else if (r_state == ST_WAIT_LOCK) begin
                    if (w_lock_s) w_state_nxt = ST_STABLE;
                end else if (!w_lock_s) begin
                    w_state_nxt = ST_WAIT_LOCK;
                end else if (r_stb == STB_LAST) begin
                    w_state_nxt = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (!w_lock_s) begin
                    w_rst_n_nxt = '0;
                    w_state_nxt = ST_RST_PLL;
                end else begin
                    for (int k = 0; k < NUM_RST; k++) begin
                        if (r_cnt == CNT_W'(k * STAGE_GAP_CYC)) w_rst_n_nxt[k] = 1'b1;
                    end
                    if (r_cnt == REL_LAST) w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!w_lock_s) begin
                    w_rst_n_nxt = '0;
                    w_state_nxt = ST_RST_PLL;
                    if (r_loss != '1) w_loss_nxt = r_loss + 1'b1;
                end
            end
            ST_FAULT:   w_state_nxt = ST_FAULT;
            default:    w_state_nxt = ST_OFF;
        endcase
        if (w_state_nxt == ST_RUN) w_retry_nxt = '0;
        if (!bus.EN) begin
            w_state_nxt = ST_OFF;
            w_rst_n_nxt = '0;
            w_retry_nxt = '0;
            w_loss_nxt  = r_loss;
        end
    end

    always_ff @(posedge CLKI or negedge RSTN) begin
        if (!RSTN) begin
            r_state   <= ST_OFF;
            r_pll_rst <= 1'b1;
            r_rst_n   <= '0;
            r_ready   <= 1'b0;
            r_fault   <= 1'b0;
            r_retry   <= '0;
            r_loss    <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_pll_rst <= (w_state_nxt == ST_OFF) || (w_state_nxt == ST_RST_PLL) ||
                         (w_state_nxt == ST_FAULT);
            r_rst_n   <= w_rst_n_nxt;
            r_ready   <= (w_state_nxt == ST_RUN);
            r_fault   <= (w_state_nxt == ST_FAULT);
            r_retry   <= w_retry_nxt;
            r_loss    <= w_loss_nxt;
        end
    end

    // Pulse/stage counter restarts on every state change; all counters hold at their end value.
    always_ff @(posedge CLKI or negedge RSTN) begin
        if (!RSTN) begin
            r_cnt <= '0;
            r_tmo <= '0;
            r_stb <= '0;
        end else begin
            if (w_state_nxt != r_state) r_cnt <= '0;
            else if (r_cnt != CNT_SAT)  r_cnt <= r_cnt + 1'b1;

            if (w_state_nxt == ST_RST_PLL) begin
                r_tmo <= '0;
            end else if ((r_state == ST_WAIT_LOCK || r_state == ST_STABLE) && !w_tmo_hit) begin
                r_tmo <= r_tmo + 1'b1;
            end

            if (r_state == ST_STABLE && w_lock_s) begin
                if (r_stb != STB_LAST) r_stb <= r_stb + 1'b1;
            end else begin
                r_stb <= '0;
            end
        end
    end

    assign bus.PLL_RST   = r_pll_rst;
    assign bus.RST_N_OUT = r_rst_n;
    assign bus.READY     = r_ready;
    assign bus.FAULT     = r_fault;
    assign bus.RETRY_CNT = r_retry;
    assign bus.LOSS_CNT  = r_loss;
    assign bus.STATE     = r_state;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with shortened timing parameters:
// a cycle-by-cycle vector table plus hand sequences for timeouts and loss saturation.
module tb_pll_lock_supervisor;

    typedef struct {
        logic       en;
        logic       lock;
        int         n;
        logic       pllRst;
        logic [2:0] rstN;
        logic       ready;
        logic       fault;
        logic [1:0] retry;
        logic [7:0] loss;
        logic [2:0] state;
    } vec_t;

    localparam int NUM_VEC = 31;

    logic clk;
    logic rstN;
    int   nCompared;
    int   nMismatched;
    vec_t vecs [NUM_VEC];

    pll_lock_supervisor_if #(.NUM_RST(3), .RETRY_W(2)) bus ();

    pll_lock_supervisor #(
        .RST_PULSE_CYC    (4),
        .LOCK_STABLE_CYC  (8),
        .LOCK_TIMEOUT_CYC (32),
        .NUM_RST          (3),
        .STAGE_GAP_CYC    (4),
        .MAX_RETRY        (2)
    ) dut (
        .CLKI (clk),
        .RSTN (rstN),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mkVec(input logic en, input logic lock, input int n,
                                   input logic pllRst, input logic [2:0] rstN_, input logic ready,
                                   input logic fault, input logic [1:0] retry, input logic [7:0] loss,
                                   input logic [2:0] state);
        vec_t v;
        v.en = en; v.lock = lock; v.n = n; v.pllRst = pllRst; v.rstN = rstN_;
        v.ready = ready; v.fault = fault; v.retry = retry; v.loss = loss; v.state = state;
        return v;
    endfunction

    function automatic logic [31:0] packOut();
        return {13'd0, bus.PLL_RST, bus.RST_N_OUT, bus.READY, bus.FAULT,
                bus.RETRY_CNT, bus.LOSS_CNT, bus.STATE};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
        end
    endtask

    task automatic checkOutputRange(input string tag, input int act, input int lo, input int hi);
        nCompared++;
        if (act < lo || act > hi) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0d, want %0d..%0d", tag, act, lo, hi);
        end
    endtask

    task automatic step(input logic en, input logic lock);
        bus.EN       = en;
        bus.PLL_LOCK = lock;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int idx);
        vec_t v;
        v = vecs[idx];
        for (int c = 0; c < v.n; c++) begin
            step(v.en, v.lock);
            checkOutput($sformatf("vec%0d.%0d", idx, c), packOut(),
                        {13'd0, v.pllRst, v.rstN, v.ready, v.fault, v.retry, v.loss, v.state});
        end
    endtask

    task automatic waitReady(input string tag, input int budget);
        int c;
        c = 0;
        while (bus.READY !== 1'b1 && c < budget) begin
            step(1'b1, 1'b1);
            c++;
        end
        nCompared++;
        if (bus.READY !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL %s: READY still %b after %0d cycles, want 1", tag, bus.READY, budget);
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic prevRst;
        int   highRun;
        int   lowRun;
        int   falls;
        logic gotFault;

        nCompared   = 0;
        nMismatched = 0;

        // Nominal bring-up, lock loss in RUN, EN fall, debounce glitch, mid-release loss.
        vecs[0]  = mkVec(0, 0, 3,  1, 3'b000, 0, 0, 0, 0, 3'd0);
        vecs[1]  = mkVec(1, 0, 4,  1, 3'b000, 0, 0, 0, 0, 3'd1);
        vecs[2]  = mkVec(1, 0, 10, 0, 3'b000, 0, 0, 0, 0, 3'd2);
        vecs[3]  = mkVec(1, 1, 2,  0, 3'b000, 0, 0, 0, 0, 3'd2);
        vecs[4]  = mkVec(1, 1, 8,  0, 3'b000, 0, 0, 0, 0, 3'd3);
        vecs[5]  = mkVec(1, 1, 1,  0, 3'b000, 0, 0, 0, 0, 3'd4);
        vecs[6]  = mkVec(1, 1, 4,  0, 3'b001, 0, 0, 0, 0, 3'd4);
        vecs[7]  = mkVec(1, 1, 4,  0, 3'b011, 0, 0, 0, 0, 3'd4);
        vecs[8]  = mkVec(1, 1, 5,  0, 3'b111, 1, 0, 0, 0, 3'd5);
        vecs[9]  = mkVec(1, 0, 2,  0, 3'b111, 1, 0, 0, 0, 3'd5);
        vecs[10] = mkVec(1, 0, 1,  1, 3'b000, 0, 0, 0, 1, 3'd1);
        vecs[11] = mkVec(1, 1, 3,  1, 3'b000, 0, 0, 0, 1, 3'd1);
        vecs[12] = mkVec(1, 1, 1,  0, 3'b000, 0, 0, 0, 1, 3'd2);
        vecs[13] = mkVec(1, 1, 8,  0, 3'b000, 0, 0, 0, 1, 3'd3);
        vecs[14] = mkVec(1, 1, 1,  0, 3'b000, 0, 0, 0, 1, 3'd4);
        vecs[15] = mkVec(1, 1, 4,  0, 3'b001, 0, 0, 0, 1, 3'd4);
        vecs[16] = mkVec(1, 1, 4,  0, 3'b011, 0, 0, 0, 1, 3'd4);
        vecs[17] = mkVec(1, 1, 3,  0, 3'b111, 1, 0, 0, 1, 3'd5);
        vecs[18] = mkVec(0, 1, 2,  1, 3'b000, 0, 0, 0, 1, 3'd0);
        vecs[19] = mkVec(1, 1, 4,  1, 3'b000, 0, 0, 0, 1, 3'd1);
        vecs[20] = mkVec(1, 1, 1,  0, 3'b000, 0, 0, 0, 1, 3'd2);
        vecs[21] = mkVec(1, 1, 4,  0, 3'b000, 0, 0, 0, 1, 3'd3);
        vecs[22] = mkVec(1, 0, 1,  0, 3'b000, 0, 0, 0, 1, 3'd3);
        vecs[23] = mkVec(1, 1, 1,  0, 3'b000, 0, 0, 0, 1, 3'd3);
        vecs[24] = mkVec(1, 1, 1,  0, 3'b000, 0, 0, 0, 1, 3'd2);
        vecs[25] = mkVec(1, 1, 8,  0, 3'b000, 0, 0, 0, 1, 3'd3);
        vecs[26] = mkVec(1, 1, 1,  0, 3'b000, 0, 0, 0, 1, 3'd4);
        vecs[27] = mkVec(1, 1, 1,  0, 3'b001, 0, 0, 0, 1, 3'd4);
        vecs[28] = mkVec(1, 0, 2,  0, 3'b001, 0, 0, 0, 1, 3'd4);
        vecs[29] = mkVec(1, 0, 1,  1, 3'b000, 0, 0, 0, 1, 3'd1);
        vecs[30] = mkVec(0, 0, 2,  1, 3'b000, 0, 0, 0, 1, 3'd0);

        rstN         = 1'b0;
        bus.EN       = 1'b0;
        bus.PLL_LOCK = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("resetState", packOut(), {13'd0, 1'b1, 3'b000, 1'b0, 1'b0, 2'd0, 8'd0, 3'd0});
        rstN = 1'b1;

        for (int i = 0; i < NUM_VEC; i++) applyStimulus(i);

        // Lock never arrives: initial pulse plus two retries, then FAULT.
        prevRst  = bus.PLL_RST;
        highRun  = 0;
        lowRun   = 0;
        falls    = 0;
        gotFault = 1'b0;
        for (int c = 0; c < 300 && !gotFault; c++) begin
            step(1'b1, 1'b0);
            if (bus.FAULT === 1'b1) gotFault = 1'b1;
            if (bus.PLL_RST === 1'b1) begin
                if (!prevRst) checkOutputRange($sformatf("lowWidth%0d", falls), lowRun, 32, 33);
                highRun++;
            end else begin
                if (prevRst) begin
                    checkOutput($sformatf("retryAtFall%0d", falls), 32'(bus.RETRY_CNT), 32'(falls));
                    if (falls > 0) checkOutput($sformatf("pulseWidth%0d", falls), 32'(highRun), 32'd4);
                    falls++;
                    highRun = 0;
                    lowRun  = 0;
                end
                lowRun++;
            end
            prevRst = bus.PLL_RST;
        end
        checkOutput("faultReached", 32'(gotFault), 32'd1);
        checkOutput("pllRstPulses", 32'(falls), 32'd3);
        repeat (5) step(1'b1, 1'b0);
        checkOutput("faultHold", packOut(), {13'd0, 1'b1, 3'b000, 1'b0, 1'b1, 2'd2, 8'd1, 3'd6});
        step(1'b0, 1'b0);
        checkOutput("faultClearByEn", packOut(), {13'd0, 1'b1, 3'b000, 1'b0, 1'b0, 2'd0, 8'd1, 3'd0});

        // Fresh reset, then 260 lock-loss events in RUN; LOSS_CNT must saturate at 255.
        @(negedge clk);
        rstN = 1'b0;
        #2;
        checkOutput("lossClearedByRstn", 32'(bus.LOSS_CNT), 32'd0);
        @(negedge clk);
        rstN = 1'b1;
        waitReady("firstRun", 100);
        for (int i = 1; i <= 260; i++) begin
            repeat (3) step(1'b1, 1'b0);
            checkOutput($sformatf("lossEvt%0d", i), {23'd0, bus.READY, bus.LOSS_CNT},
                        {23'd0, 1'b0, 8'((i > 255) ? 255 : i)});
            waitReady($sformatf("rerun%0d", i), 100);
        end
        checkOutput("finalRun", packOut(), {13'd0, 1'b0, 3'b111, 1'b1, 1'b0, 2'd0, 8'd255, 3'd5});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
